// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
package hazard_pkg;

   localparam int FWD_REGFILE  = 0;
   localparam int ZERO_REG     = 0;
   // Destination field is sized for the largest supported register file.
   localparam int ENTRY_DEST_W = 8;

   typedef struct packed {
      logic                    valid;
      logic                    writes;
      logic                    is_load;
      logic [ENTRY_DEST_W-1:0] dest;
   } entry_t;

   function automatic int sel_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority encoder over the in-flight entries for one decode operand:
// reports whether any entry writes the operand, the youngest such stage, and its load flag.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int SEL_W = 2,
   parameter int REG_W = 5
)(
   input  entry_t [DEPTH-1:0] entries,
   input  logic   [REG_W-1:0] src,
   input  logic               uses,
   output logic               hit,
   output logic   [SEL_W-1:0] stage,
   output logic               is_load
);

   always_comb begin
      hit     = 1'b0;
      stage   = '0;
      is_load = 1'b0;
      if (uses && src != REG_W'(ZERO_REG)) begin
         // Scan oldest to youngest so the youngest match is the last one written.
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (entries[k].valid && entries[k].writes &&
                entries[k].dest == ENTRY_DEST_W'(src)) begin
               hit     = 1'b1;
               stage   = SEL_W'(k + 1);
               is_load = entries[k].is_load;
            end
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight destinations and resolves operands
// to forward / register file / stall. Define HAZARD_FWD_EN for forwarding; otherwise stall-only.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter  int NUM_REGS   = 32,
   parameter  int DEPTH      = 3,
   parameter  int LOAD_READY = 2,
   parameter  int CNT_W      = 16,
   localparam int REG_W      = $clog2(NUM_REGS),
   localparam int SEL_W      = sel_width(DEPTH)
)(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             IssueValid,
   input  logic             IssueWrites,
   input  logic             IssueIsLoad,
   input  logic [REG_W-1:0] IssueDest,
   input  logic [REG_W-1:0] SrcA,
   input  logic [REG_W-1:0] SrcB,
   input  logic             UsesA,
   input  logic             UsesB,
   input  logic             Flush,
   output logic             Stall,
   output logic [SEL_W-1:0] FwdSelA,
   output logic [SEL_W-1:0] FwdSelB,
   output logic [CNT_W-1:0] StallCount
);

   // Index 0 holds stage 1 (execute); index DEPTH-1 holds writeback.
   entry_t [DEPTH-1:0] entry_reg;
   entry_t             issue_entry;
   logic   [CNT_W-1:0] stall_count_reg;

   logic [REG_W-1:0] src     [2];
   logic [1:0]       uses;
   logic [1:0]       hazard;
   logic [SEL_W-1:0] fwd_sel [2];

   assign src[0]  = SrcA;
   assign src[1]  = SrcB;
   assign uses    = {UsesB, UsesA};
   assign FwdSelA = fwd_sel[0];
   assign FwdSelB = fwd_sel[1];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_operand
         logic             hit;
         logic [SEL_W-1:0] stage;
         logic             is_load;
         logic             hz;
         logic [SEL_W-1:0] sel;

         hazard_match #(
            .DEPTH (DEPTH),
            .SEL_W (SEL_W),
            .REG_W (REG_W)
         ) u_match (
            .entries (entry_reg),
            .src     (src[gi]),
            .uses    (uses[gi]),
            .hit     (hit),
            .stage   (stage),
            .is_load (is_load)
         );

         always_comb begin
            hz  = 1'b0;
            sel = SEL_W'(FWD_REGFILE);
`ifdef HAZARD_FWD_EN
            if (hit) begin
               // Load data is not available before LOAD_READY; stall instead of forwarding.
               if (is_load && int'(stage) < LOAD_READY) begin
                  hz = 1'b1;
               end else begin
                  sel = stage;
               end
            end
`else
            hz = hit;
`endif
         end

`ifndef HAZARD_FWD_EN
         logic unused_match;
         assign unused_match = ^{stage, is_load, (LOAD_READY > 0)};
`endif

         assign hazard[gi]  = hz;
         assign fwd_sel[gi] = sel;
      end
   endgenerate

   assign Stall = IssueValid & ~Flush & (|hazard);

   always_comb begin
      issue_entry = '0;
      if (IssueValid && !Flush && !Stall) begin
         issue_entry.valid   = 1'b1;
         issue_entry.writes  = IssueWrites;
         issue_entry.is_load = IssueIsLoad;
         issue_entry.dest    = ENTRY_DEST_W'(IssueDest);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         entry_reg       <= '0;
         stall_count_reg <= '0;
      end else begin
         entry_reg[0] <= issue_entry;
         for (int k = 1; k < DEPTH; k++) begin
            entry_reg[k] <= entry_reg[k-1];
         end
         if (Stall && stall_count_reg != {CNT_W{1'b1}}) begin
            stall_count_reg <= stall_count_reg + 1'b1;
         end
      end
   end

   assign StallCount = stall_count_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow HAZARD_FWD_EN when defined.
module tb_hazard_scoreboard;

   localparam int NUM_REGS   = 32;
   localparam int DEPTH      = 3;
   localparam int LOAD_READY = 2;
   localparam int CNT_W      = 8;
   localparam int REG_W      = 5;
   localparam int SEL_W      = 2;

   logic             Clk = 1'b0;
   logic             Reset = 1'b0;
   logic             IssueValid, IssueWrites, IssueIsLoad, UsesA, UsesB, Flush;
   logic [REG_W-1:0] IssueDest, SrcA, SrcB;
   logic             Stall;
   logic [SEL_W-1:0] FwdSelA, FwdSelB;
   logic [CNT_W-1:0] StallCount;

   int n_cmp   = 0;
   int n_err   = 0;
   int exp_cnt = 0;

   hazard_scoreboard #(
      .NUM_REGS   (NUM_REGS),
      .DEPTH      (DEPTH),
      .LOAD_READY (LOAD_READY),
      .CNT_W      (CNT_W)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .IssueValid  (IssueValid),
      .IssueWrites (IssueWrites),
      .IssueIsLoad (IssueIsLoad),
      .IssueDest   (IssueDest),
      .SrcA        (SrcA),
      .SrcB        (SrcB),
      .UsesA       (UsesA),
      .UsesB       (UsesB),
      .Flush       (Flush),
      .Stall       (Stall),
      .FwdSelA     (FwdSelA),
      .FwdSelB     (FwdSelB),
      .StallCount  (StallCount)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic drive(input int v, input int w, input int ld, input int d,
                        input int sa, input int ua, input int sb, input int ub, input int fl);
      IssueValid  = 1'(v);
      IssueWrites = 1'(w);
      IssueIsLoad = 1'(ld);
      IssueDest   = REG_W'(d);
      SrcA        = REG_W'(sa);
      UsesA       = 1'(ua);
      SrcB        = REG_W'(sb);
      UsesB       = 1'(ub);
      Flush       = 1'(fl);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      @(negedge Clk);
   endtask

   task automatic drain();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (DEPTH) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge Clk);
      settle();
      check_eq("rst_stall", 32'(Stall), 0);
      check_eq("rst_fwda", 32'(FwdSelA), 0);
      check_eq("rst_fwdb", 32'(FwdSelB), 0);
      check_eq("rst_cnt", 32'(StallCount), 0);
      Reset = 1'b1;
      tick();

      // ALU result consumed by the next instruction
      drive(1, 1, 0, 8, 0, 0, 0, 0, 0);
      settle();
      check_eq("alu_wr_stall", 32'(Stall), 0);
      tick();
      drive(1, 0, 0, 0, 8, 1, 0, 0, 0);
`ifdef HAZARD_FWD_EN
      settle();
      check_eq("alu_fwda", 32'(FwdSelA), 1);
      check_eq("alu_stall", 32'(Stall), 0);
      tick();
`else
      for (int c = 0; c < 3; c++) begin
         settle();
         check_eq("alu_stall_on", 32'(Stall), 1);
         check_eq("alu_fwda", 32'(FwdSelA), 0);
         tick();
      end
      settle();
      check_eq("alu_stall_off", 32'(Stall), 0);
      tick();
      exp_cnt += 3;
`endif
      drain();
      settle();
      check_eq("alu_cnt", 32'(StallCount), 32'(exp_cnt));

      // Load-use
      drive(1, 1, 1, 9, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 0, 9, 1, 0);
      settle();
      check_eq("lu_stall1", 32'(Stall), 1);
      check_eq("lu_fwdb1", 32'(FwdSelB), 0);
      tick();
`ifdef HAZARD_FWD_EN
      exp_cnt += 1;
      settle();
      check_eq("lu_fwdb2", 32'(FwdSelB), 2);
      check_eq("lu_stall2", 32'(Stall), 0);
      check_eq("lu_cnt", 32'(StallCount), 32'(exp_cnt));
      tick();
`else
      repeat (2) begin
         settle();
         check_eq("lu_stall_on", 32'(Stall), 1);
         tick();
      end
      exp_cnt += 3;
      settle();
      check_eq("lu_stall_off", 32'(Stall), 0);
      check_eq("lu_fwdb", 32'(FwdSelB), 0);
      check_eq("lu_cnt", 32'(StallCount), 32'(exp_cnt));
      tick();
`endif
      drain();

      // Youngest writer wins
      drive(1, 1, 0, 10, 0, 0, 0, 0, 0);
      tick();
      tick();
      drive(1, 0, 0, 0, 10, 1, 0, 0, 0);
      settle();
`ifdef HAZARD_FWD_EN
      check_eq("young_fwda", 32'(FwdSelA), 1);
      check_eq("young_stall", 32'(Stall), 0);
`else
      check_eq("young_fwda", 32'(FwdSelA), 0);
      check_eq("young_stall", 32'(Stall), 1);
      exp_cnt += 1;
`endif
      tick();
      drain();

      // Register zero never matches
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
      settle();
      check_eq("zero_stall", 32'(Stall), 0);
      check_eq("zero_fwda", 32'(FwdSelA), 0);
      check_eq("zero_fwdb", 32'(FwdSelB), 0);
      tick();
      drain();

      // Flushed load leaves a bubble
      drive(1, 1, 1, 9, 0, 0, 0, 0, 1);
      tick();
      drive(1, 0, 0, 0, 0, 0, 9, 1, 0);
      settle();
      check_eq("flush_stall", 32'(Stall), 0);
      check_eq("flush_fwdb", 32'(FwdSelB), 0);
      tick();
      drain();

      // Flush wins over a live hazard
      drive(1, 1, 1, 9, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 0, 9, 1, 1);
      settle();
      check_eq("flushhz_stall", 32'(Stall), 0);
      tick();
      drive(1, 0, 0, 0, 0, 0, 9, 1, 0);
      settle();
`ifdef HAZARD_FWD_EN
      check_eq("flushhz_fwdb", 32'(FwdSelB), 2);
      check_eq("flushhz_stall2", 32'(Stall), 0);
`else
      check_eq("flushhz_fwdb", 32'(FwdSelB), 0);
      check_eq("flushhz_stall2", 32'(Stall), 1);
      exp_cnt += 1;
`endif
      tick();
      drain();

      // Instruction reading its own destination sees only older entries
      drive(1, 1, 0, 11, 11, 1, 0, 0, 0);
      settle();
      check_eq("self_stall", 32'(Stall), 0);
      check_eq("self_fwda", 32'(FwdSelA), 0);
      tick();
      drain();
      settle();
      check_eq("pre_rst_cnt", 32'(StallCount), 32'(exp_cnt));

      // Reset asserted in the middle of a stall
      drive(1, 1, 1, 12, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 12, 1, 0, 0, 0);
      settle();
      check_eq("mid_stall", 32'(Stall), 1);
      #1 Reset = 1'b0;
      #1;
      check_eq("mid_rst_stall", 32'(Stall), 0);
      check_eq("mid_rst_fwda", 32'(FwdSelA), 0);
      check_eq("mid_rst_fwdb", 32'(FwdSelB), 0);
      check_eq("mid_rst_cnt", 32'(StallCount), 0);
      #1 Reset = 1'b1;
      #1;
      check_eq("post_rst_stall", 32'(Stall), 0);
      exp_cnt = 0;
      tick();
      drain();
      settle();
      check_eq("post_rst_cnt", 32'(StallCount), 0);

      // Counter saturation: self-dependent load stream stalls repeatedly
      drive(1, 1, 1, 5, 5, 1, 0, 0, 0);
      repeat (1024) tick();
      settle();
      check_eq("sat_cnt", 32'(StallCount), 255);
      tick();
      repeat (64) tick();
      settle();
      check_eq("sat_hold", 32'(StallCount), 255);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
